// File: rtl/mc_datapath_hs_if.sv
// Memory/IO bus between the multicycle datapath (master) and the memory system (slave).
interface mc_datapath_hs_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mc_datapath_hs.sv
// Parametrised multicycle datapath (IR/MDR/regfile/ALU/ALUOut/PC) with a
// request/ready memory handshake; a wait-state FSM stalls architectural updates.
module mc_datapath_hs #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREG     = 32,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IorD,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               IRWrite,
    input  logic [1:0]         RegDst,
    input  logic               RegWrite,
    input  logic [1:0]         MemtoReg,
    input  logic               ALUSrcA,
    input  logic [2:0]         ALUSrcB,
    input  logic [1:0]         PCSource,
    input  logic               PCWrite,
    input  logic               PCWriteCond,
    input  logic               BranchNE,
    input  logic [3:0]         ALU_operation,
    mc_datapath_hs_if.master   mem,
    output logic               stall,
    output logic [XLEN-1:0]    PC_Current,
    output logic [31:0]        Inst,
    output logic               zero,
    output logic               overflow
);
    localparam int unsigned SHW    = $clog2(XLEN);
    localparam int unsigned RIW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0]  NREG_W = 6'(NREG);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, mdr, alu_out;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [NREG];

    logic [4:0]      rs, rt, rd, sa, wsel;
    logic [15:0]     imm;
    logic [XLEN-1:0] rs_data, rt_data, imm_sx, imm_hi;
    logic [XLEN-1:0] alu_a, alu_b, alu_res, sum, diff, pc_nxt, rf_wdata;
    logic [SHW-1:0]  shamt;
    logic            rd_done, pc_we, rf_we;

    assign rs  = ir[25:21];
    assign rt  = ir[20:16];
    assign rd  = ir[15:11];
    assign sa  = ir[10:6];
    assign imm = ir[15:0];

    assign imm_sx = XLEN'($signed(imm));
    assign imm_hi = XLEN'($signed({imm, 16'h0000}));

    // x0 and unimplemented indices read as zero
    assign rs_data = (rs != 5'd0 && {1'b0, rs} < NREG_W) ? rf[RIW'(rs)] : '0;
    assign rt_data = (rt != 5'd0 && {1'b0, rt} < NREG_W) ? rf[RIW'(rt)] : '0;

    // Wait-state FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Handshake next-state and request/stall decode; reset drops the request at once
    always_comb begin
        state_nxt   = state;
        mem.mem_req = 1'b0;
        stall       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MemRead | MemWrite) begin
                    mem.mem_req = 1'b1;
                    if (!mem.mem_ready) begin
                        stall     = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                mem.mem_req = 1'b1;
                stall       = !mem.mem_ready;
                if (mem.mem_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!reset) begin
            mem.mem_req = 1'b0;
            stall       = 1'b0;
        end
    end

    assign mem.mem_we    = MemWrite;
    assign mem.mem_addr  = IorD ? alu_out : pc;
    assign mem.mem_wdata = rt_data;
    assign rd_done       = mem.mem_req & mem.mem_ready & ~MemWrite;

    assign alu_a = ALUSrcA ? pc : rs_data;
    assign shamt = alu_b[SHW-1:0];
    assign sum   = alu_a + alu_b;
    assign diff  = alu_a - alu_b;

    always_comb begin
        case (ALUSrcB)
            3'd0:    alu_b = rt_data;
            3'd1:    alu_b = XLEN'(PC_STEP);
            3'd2:    alu_b = imm_sx;
            3'd3:    alu_b = imm_sx << 2;
            3'd4:    alu_b = XLEN'(sa);
            default: alu_b = '0;
        endcase
    end

    // ALU; overflow only meaningful for ADD/SUB
    always_comb begin
        alu_res  = '0;
        overflow = 1'b0;
        case (ALU_operation)
            4'd0: alu_res = alu_a & alu_b;
            4'd1: alu_res = alu_a | alu_b;
            4'd2: begin
                alu_res  = sum;
                overflow = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (sum[XLEN-1] != alu_a[XLEN-1]);
            end
            4'd3: alu_res = alu_a ^ alu_b;
            4'd4: alu_res = ~(alu_a | alu_b);
            4'd5: alu_res = alu_a >> shamt;
            4'd6: begin
                alu_res  = diff;
                overflow = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (diff[XLEN-1] != alu_a[XLEN-1]);
            end
            4'd7: alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            4'd8: alu_res = alu_a << shamt;
            4'd9: alu_res = XLEN'($signed(alu_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    assign zero = (alu_res == '0);

    always_comb begin
        case (PCSource)
            2'd0:    pc_nxt = alu_res;
            2'd1:    pc_nxt = alu_out;
            2'd2:    pc_nxt = {pc[XLEN-1:28], ir[25:0], 2'b00};
            default: pc_nxt = rs_data;
        endcase
        case (RegDst)
            2'd0:    wsel = rt;
            2'd1:    wsel = rd;
            2'd2:    wsel = 5'd31;
            default: wsel = 5'd0;
        endcase
        case (MemtoReg)
            2'd0:    rf_wdata = alu_out;
            2'd1:    rf_wdata = mdr;
            2'd2:    rf_wdata = pc;
            default: rf_wdata = imm_hi;
        endcase
    end

    assign pc_we = !stall & (PCWrite | (PCWriteCond & (zero ^ BranchNE)));
    assign rf_we = !stall & RegWrite & (wsel != 5'd0) & ({1'b0, wsel} < NREG_W);

    // Architectural state; every update is held off while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            alu_out <= '0;
            for (int unsigned i = 0; i < NREG; i++) rf[RIW'(i)] <= '0;
        end else begin
            if (!stall) alu_out <= alu_res;
            if (pc_we)  pc      <= pc_nxt;
            if (rd_done) begin
                mdr <= mem.mem_rdata;
                if (IRWrite) ir <= mem.mem_rdata[31:0];
            end
            if (rf_we) rf[RIW'(wsel)] <= rf_wdata;
        end
    end

    assign PC_Current = pc;
    assign Inst       = ir;
endmodule

// File: tb/tb_mc_datapath_hs.sv
// Bench for mc_datapath_hs: directed literal checks plus a random run compared
// every cycle against an architectural model of the datapath and memory handshake.
module tb_mc_datapath_hs;
    localparam int          XLEN   = 32;
    localparam int          NREG   = 16;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic        PCWrite, PCWriteCond, BranchNE;
    logic [1:0]  RegDst, MemtoReg, PCSource;
    logic [2:0]  ALUSrcB;
    logic [3:0]  ALU_operation;
    logic        stall, zero, overflow;
    logic [31:0] PC_Current, Inst;

    mc_datapath_hs_if #(.XLEN(XLEN)) bus ();

    mc_datapath_hs #(
        .XLEN(XLEN), .NREG(NREG), .PC_STEP(4), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .ALU_operation(ALU_operation),
        .mem(bus), .stall(stall), .PC_Current(PC_Current), .Inst(Inst),
        .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit exp_stall_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model state
    logic [31:0] m_pc, m_ir, m_mdr, m_alo;
    logic [31:0] m_rf [32];
    bit          m_wait;

    function automatic logic [31:0] m_rd(input int idx);
        return (idx == 0 || idx >= NREG) ? 32'h0 : m_rf[idx];
    endfunction

    function automatic logic [31:0] sx16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] f_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic ovf);
        longint      sa, sb, r;
        logic [31:0] s32;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = 1'b0;
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: begin
                r = sa + sb; s32 = r[31:0];
                ovf = (r != longint'($signed(s32)));
                return s32;
            end
            4'd3: return a ^ b;
            4'd4: return ~(a | b);
            4'd5: return a >> b[4:0];
            4'd6: begin
                r = sa - sb; s32 = r[31:0];
                ovf = (r != longint'($signed(s32)));
                return s32;
            end
            4'd7: return (sa < sb) ? 32'd1 : 32'd0;
            4'd8: return a << b[4:0];
            4'd9: return $signed(a) >>> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    // Compare process: check outputs, then advance the model across the coming edge
    always @(negedge clk) begin : model
        logic [31:0] a, b, res, wd, tgt;
        logic        ovf, req, stl, zf;
        int          rs, rt, rd, dst;
        rs = int'(m_ir[25:21]);
        rt = int'(m_ir[20:16]);
        rd = int'(m_ir[15:11]);
        a  = ALUSrcA ? m_pc : m_rd(rs);
        case (ALUSrcB)
            3'd0:    b = m_rd(rt);
            3'd1:    b = 32'd4;
            3'd2:    b = sx16(m_ir[15:0]);
            3'd3:    b = sx16(m_ir[15:0]) * 32'd4;
            3'd4:    b = {27'b0, m_ir[10:6]};
            default: b = 32'h0;
        endcase
        res = f_alu(ALU_operation, a, b, ovf);
        zf  = (res == 32'h0);
        req = reset && (m_wait || MemRead || MemWrite);
        stl = req && !bus.mem_ready;
        if (chk_en) begin
            check("mem_req",   32'(bus.mem_req), 32'(req));
            check("stall",     32'(stall),       32'(stl));
            check("mem_we",    32'(bus.mem_we),  32'(MemWrite));
            check("mem_addr",  bus.mem_addr,     IorD ? m_alo : m_pc);
            check("mem_wdata", bus.mem_wdata,    m_rd(rt));
            check("pc",        PC_Current,       m_pc);
            check("inst",      Inst,             m_ir);
            check("zero",      32'(zero),        32'(zf));
            check("overflow",  32'(overflow),    32'(ovf));
        end
        exp_stall_q = stl;
        if (!reset) begin
            m_pc = RST_PC; m_ir = 0; m_mdr = 0; m_alo = 0; m_wait = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
        end else if (stl) begin
            m_wait = 1;
        end else begin
            m_wait = 0;
            case (MemtoReg)
                2'd0:    wd = m_alo;
                2'd1:    wd = m_mdr;
                2'd2:    wd = m_pc;
                default: wd = {m_ir[15:0], 16'h0000};
            endcase
            case (PCSource)
                2'd0:    tgt = res;
                2'd1:    tgt = m_alo;
                2'd2:    tgt = {m_pc[31:28], m_ir[25:0], 2'b00};
                default: tgt = m_rd(rs);
            endcase
            dst = (RegDst == 2'd0) ? rt : (RegDst == 2'd1) ? rd : (RegDst == 2'd2) ? 31 : 0;
            if (PCWrite || (PCWriteCond && (zf != BranchNE))) m_pc = tgt;
            if (RegWrite && dst != 0 && dst < NREG) m_rf[dst] = wd;
            if (req && !MemWrite) begin
                m_mdr = bus.mem_rdata;
                if (IRWrite) m_ir = bus.mem_rdata;
            end
            m_alo = res;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        IorD = 0; MemRead = 0; MemWrite = 0; IRWrite = 0; RegDst = 0; RegWrite = 0;
        MemtoReg = 0; ALUSrcA = 0; ALUSrcB = 0; PCSource = 0; PCWrite = 0;
        PCWriteCond = 0; BranchNE = 0; ALU_operation = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
    endtask

    task automatic fetch(input logic [31:0] w);
        set_idle();
        MemRead = 1; IRWrite = 1; bus.mem_ready = 1; bus.mem_rdata = w;
        tick();
        set_idle();
    endtask

    task automatic load_mdr(input logic [31:0] w);
        set_idle();
        MemRead = 1; IorD = 1; bus.mem_ready = 1; bus.mem_rdata = w;
        tick();
        set_idle();
    endtask

    initial begin
        reset = 0;
        set_idle();
        tick(); tick();
        chk_en = 1;
        check("rst_pc", PC_Current, 32'h100);
        check("rst_inst", Inst, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_req", 32'(bus.mem_req), 32'h0);
        reset = 1;

        // zero-wait fetch with PC+4
        MemRead = 1; IRWrite = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h2008_0005;
        ALUSrcA = 1; ALUSrcB = 1; ALU_operation = 2; PCWrite = 1;
        #1;
        check("zw_stall", 32'(stall), 32'h0);
        check("zw_req", 32'(bus.mem_req), 32'h1);
        check("zw_addr", bus.mem_addr, 32'h100);
        tick();
        check("zw_inst", Inst, 32'h2008_0005);
        check("zw_pc", PC_Current, 32'h104);

        // three wait states, then one completion
        bus.mem_ready = 0; bus.mem_rdata = 32'h8C0A_0010;
        for (int i = 0; i < 3; i++) begin
            #1 check("ws_stall", 32'(stall), 32'h1);
            tick();
            check("ws_pc_hold", PC_Current, 32'h104);
            check("ws_ir_hold", Inst, 32'h2008_0005);
        end
        bus.mem_ready = 1;
        #1 check("ws_done_stall", 32'(stall), 32'h0);
        tick();
        check("ws_inst", Inst, 32'h8C0A_0010);
        check("ws_pc", PC_Current, 32'h108);
        set_idle();
        tick();
        check("ws_pc_once", PC_Current, 32'h108);

        // x0 and unimplemented r20 drop writes; r5 keeps them
        fetch(32'h0000_A000);
        load_mdr(32'h0000_DEAD);
        RegWrite = 1; MemtoReg = 1; RegDst = 0; tick();
        RegDst = 1; tick();
        fetch(32'h0280_2800);
        load_mdr(32'h0000_DEAD);
        RegWrite = 1; MemtoReg = 1; RegDst = 1; tick();
        set_idle();
        ALU_operation = 1; ALUSrcB = 5;
        #1;
        check("r20_zero", 32'(zero), 32'h1);
        check("r0_read", bus.mem_wdata, 32'h0);
        fetch(32'h00A5_0000);
        #1 check("r5_read", bus.mem_wdata, 32'h0000_DEAD);

        // BNE: r7 = 7, r3 = 3
        fetch(32'h0007_0007);
        ALUSrcB = 2; ALU_operation = 2; tick();
        RegWrite = 1; RegDst = 0; MemtoReg = 0; tick();
        fetch(32'h0003_0003);
        ALUSrcB = 2; ALU_operation = 2; tick();
        RegWrite = 1; RegDst = 0; MemtoReg = 0; tick();
        fetch(32'h00E7_0000);
        ALU_operation = 6; PCWriteCond = 1; BranchNE = 1; PCSource = 1;
        #1 check("bne_eq_zero", 32'(zero), 32'h1);
        tick();
        check("bne_not_taken", PC_Current, 32'h108);
        fetch(32'h00E3_0004);
        ALUSrcA = 1; ALUSrcB = 3; ALU_operation = 2; tick();
        set_idle();
        ALU_operation = 6; PCWriteCond = 1; BranchNE = 1; PCSource = 1;
        #1 check("bne_ne_zero", 32'(zero), 32'h0);
        tick();
        check("bne_taken", PC_Current, 32'h118);

        // signed overflow: r9 = 0x80000000, r10 = r9 - 1, then r10 + 1
        fetch(32'h0009_8000);
        MemtoReg = 3; RegDst = 0; RegWrite = 1; tick();
        fetch(32'h012A_0001);
        ALUSrcB = 2; ALU_operation = 6; tick();
        RegWrite = 1; RegDst = 0; MemtoReg = 0; tick();
        fetch(32'h0140_0001);
        ALUSrcB = 2; ALU_operation = 2;
        #1;
        check("ovf_add", 32'(overflow), 32'h1);
        check("ovf_zero", 32'(zero), 32'h0);
        set_idle();

        // reset while waiting drops the request; a late ready is ignored
        MemRead = 1;
        #1 check("wr_stall", 32'(stall), 32'h1);
        tick();
        check("wr_req_wait", 32'(bus.mem_req), 32'h1);
        reset = 0;
        #1 check("wr_req_drop", 32'(bus.mem_req), 32'h0);
        tick();
        reset = 1; MemRead = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("wr_req_after", 32'(bus.mem_req), 32'h0);
        check("wr_pc_after", PC_Current, 32'h100);
        tick();
        check("wr_ir_after", Inst, 32'h0);

        // randomized run; controls held while the model expects a stall
        for (int c = 0; c < 3000; c++) begin
            if (!exp_stall_q) begin
                IorD          = 1'($urandom_range(0, 1));
                MemRead       = ($urandom_range(0, 2) == 0);
                MemWrite      = ($urandom_range(0, 4) == 0);
                IRWrite       = 1'($urandom_range(0, 1));
                RegDst        = 2'($urandom_range(0, 3));
                RegWrite      = 1'($urandom_range(0, 1));
                MemtoReg      = 2'($urandom_range(0, 3));
                ALUSrcA       = 1'($urandom_range(0, 1));
                ALUSrcB       = 3'($urandom_range(0, 7));
                PCSource      = 2'($urandom_range(0, 3));
                PCWrite       = ($urandom_range(0, 3) == 0);
                PCWriteCond   = 1'($urandom_range(0, 1));
                BranchNE      = 1'($urandom_range(0, 1));
                ALU_operation = 4'($urandom_range(0, 15));
            end
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            bus.mem_rdata = $urandom();
            reset         = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset = 1;
        set_idle();
        tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_datapath_hs.md
Name: mc_datapath_hs

Overview:
- Parametrised successor to the fixed 32-bit multicycle datapath: same IR/MDR/regfile/ALU/ALUOut/PC structure and control-input style.
- Adds configurable data width, register count, PC step and reset vector.
- Replaces the tied-high memory-ready input with a request/ready handshake. An internal wait-state FSM stalls all architectural updates until memory responds.
- Sits between the multicycle controller and the memory/IO bus.

Parameters:
- XLEN, 32, datapath/register/PC width; legal 32 or 64.
- NREG, 32, implemented registers (2..32); x0 reads 0, writes ignored.
- PC_STEP, 4, value on ALUSrcB=1 (PC increment).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- IorD  in  1  0: mem_addr=PC, 1: mem_addr=ALUOut.
- MemRead  in  1  request a read this step.
- MemWrite  in  1  request a write this step.
- IRWrite  in  1  load IR on read completion.
- RegDst  in  2  0 rt, 1 rd, 2 r31, 3 r0.
- RegWrite  in  1  register write enable.
- MemtoReg  in  2  0 ALUOut, 1 MDR, 2 PC, 3 {imm,16'b0} sign-extended to XLEN.
- ALUSrcA  in  1  0 rs, 1 PC.
- ALUSrcB  in  3  0 rt, 1 PC_STEP, 2 sext imm, 3 sext imm<<2, 4 zero-extended sa, 5-7 zero.
- PCSource  in  2  0 alu_res, 1 ALUOut, 2 jump {PC[XLEN-1:28],Inst[25:0],2'b00}, 3 rs.
- PCWrite  in  1  unconditional PC write.
- PCWriteCond  in  1  conditional PC write.
- BranchNE  in  1  0 take on zero, 1 take on !zero.
- ALU_operation  in  4  0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SRL, 6 SUB, 7 SLT signed, 8 SLL, 9 SRA, others 0.
- mem_ready  in  1  memory completes the current request.
- mem_rdata  in  32/XLEN  read data. Low 32 bits feed IR; full width feeds MDR.
- mem_req  out  1  request valid.
- mem_we  out  1  request is a write.
- mem_addr  out  XLEN  request address.
- mem_wdata  out  XLEN  rt read data.
- stall  out  1  controller must hold its current step.
- PC_Current  out  XLEN  PC register.
- Inst  out  32  IR.
- zero  out  1  alu_res==0.
- overflow  out  1  signed overflow; ADD/SUB only, else 0.

Behaviour:
- Reset (reset=0 at edge): PC=RESET_PC, IR=0, MDR=0, ALUOut=0, all registers 0, FSM=IDLE. mem_req=0 and stall=0 while in IDLE with no request.
- FSM states: IDLE, WAIT.
- IDLE:
  - If MemRead or MemWrite is high, assert mem_req combinationally.
  - mem_we = MemWrite; MemWrite wins if both are high.
  - If mem_ready is high in the same cycle: zero-wait completion, stall=0, stay IDLE.
  - Otherwise stall=1 and go to WAIT.
- WAIT:
  - mem_req=1; stall = !mem_ready.
  - Address and write data come from the controller-held inputs; the controller must not change them while stall=1.
  - On mem_ready: return to IDLE.
- Read completion (ready cycle):
  - MDR <= mem_rdata.
  - IR <= mem_rdata[31:0] if IRWrite.
- IR and MDR are never loaded outside a read completion.
- While stall=1, all of the following are suppressed: PC write, register write, ALUOut load, IR load, MDR load.
- ALUOut loads alu_res every non-stalled cycle.
- PC write enable = !stall & (PCWrite | (PCWriteCond & (zero ^ BranchNE))).
- Register file:
  - 2 asynchronous reads, 1 synchronous write.
  - Reads of x0 or of an index >= NREG return 0.
  - Writes to x0 or to an index >= NREG are dropped.
  - Write-then-read of the same register returns the new value the next cycle; no bypass.
- Shifts use alu_B[log2(XLEN)-1:0]. Shift source is alu_A.
- SLT result is 1 or 0, zero-extended.
- reset=0 while in WAIT: return to IDLE and drop mem_req immediately; any late mem_ready is ignored.
- MemRead and MemWrite both low while in WAIT is a protocol violation; the request is still completed.

Test Plan:
- Reset: hold reset=0 for 2 cycles with RESET_PC=0x100 -> PC_Current=0x100, Inst=0, stall=0, mem_req=0.
- Zero-wait fetch: IorD=0, MemRead=1, IRWrite=1, mem_ready=1, mem_rdata=0x2008_0005; ALUSrcA=1, ALUSrcB=1, ALU_operation=2, PCWrite=1 -> next edge: Inst=0x20080005, PC=0x104, stall never high.
- 3-wait fetch: mem_ready low for 3 cycles -> stall=1 for 3 cycles; PC, IR and regs unchanged; on the 4th cycle Inst is loaded and PC+4 is taken once.
- x0 and NREG=16: write 0xDEAD to r0 and to r20 -> both read 0; write to r5 -> r5 reads 0xDEAD.
- BNE: rs=rt=7, ALU SUB, PCWriteCond=1, BranchNE=1 -> PC unchanged. Repeat with rs=7, rt=3 -> PC=ALUOut.
- Overflow with XLEN=32: ADD 0x7FFF_FFFF+1 -> overflow=1, zero=0. Reset asserted in WAIT -> mem_req=0 the next cycle.
